// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared GRB colours, FSM encoding and matrix geometry for the WS2812 bar driver
package ws2812_pkg;

  localparam int LED_COLS = 8;
  localparam int LED_ROWS = 8;

  localparam logic [23:0] COL_OFF    = 24'h000000;
  localparam logic [23:0] COL_GREEN  = 24'h200000;
  localparam logic [23:0] COL_YELLOW = 24'h202000;
  localparam logic [23:0] COL_RED    = 24'h002000;
  localparam logic [23:0] COL_PEAK   = 24'h202020;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } fsm_t;

  // Bottom three rows green, middle three yellow, top two red.
  function automatic logic [23:0] row_colour(input logic [2:0] row);
    if (row < 3'd3)      return COL_GREEN;
    else if (row < 3'd6) return COL_YELLOW;
    else                 return COL_RED;
  endfunction

  function automatic logic [2:0] hi_row(input logic [7:0] bars);
    logic [2:0] hi;
    hi = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bars[i]) hi = 3'(i);
    end
    return hi;
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// rtl/ws2812_bit_tx.sv - serialises one 24-bit GRB pixel MSB first with WS2812 NRZ bit timing
module ws2812_bit_tx #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel,
  input  logic        load,
  output logic        dout,
  output logic        pixel_done
);

  localparam int CW = $clog2(TBIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] HI0      = CW'(T0H);
  localparam logic [CW-1:0] HI1      = CW'(T1H);

  logic [23:0]   sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;
  logic          act_q, act_d;
  logic          bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      act_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      act_q <= act_d;
    end
  end

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_d      = act_q;
    bit_end    = act_q && (cnt_q == CNT_LAST);
    pixel_done = bit_end && (idx_q == 5'd23);
    if (bit_end) begin
      cnt_d = '0;
      sr_d  = {sr_q[22:0], 1'b0};
      idx_d = idx_q + 5'd1;
      if (pixel_done) begin
        idx_d = '0;
        act_d = 1'b0;
      end
    end else if (act_q) begin
      cnt_d = cnt_q + CW'(1);
    end
    // A load on the final cycle of a pixel chains straight into the next one.
    if (load) begin
      sr_d  = pixel;
      cnt_d = '0;
      idx_d = '0;
      act_d = 1'b1;
    end
    dout = act_q && (cnt_q < (sr_q[23] ? HI1 : HI0));
  end

endmodule

// File: rtl/ws2812_bar_drv.sv
// rtl/ws2812_bar_drv.sv - renders 8 thermometer bars onto an 8x8 WS2812 matrix, frame after frame
// Optional peak-hold markers are enabled by defining WS2812_BAR_PEAK_HOLD_EN.
module ws2812_bar_drv
  import ws2812_pkg::*;
#(
  parameter int T0H               = 20,
  parameter int T1H               = 40,
  parameter int TBIT              = 63,
  parameter int TRST              = 15000,
  parameter int SERPENTINE        = 1,
  parameter int PEAK_DECAY_FRAMES = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [LED_COLS-1:0][LED_ROWS-1:0]      bar_data,
  input  logic                                   bar_valid,
  output logic                                   ws2812_dout,
  output logic                                   frame_busy,
  output logic                                   frame_done
);

  localparam int GW = $clog2(TRST + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TRST - 1);

  fsm_t                               state_q, state_d;
  logic [GW-1:0]                      gap_q, gap_d;
  logic [5:0]                         pix_q, pix_d;
  logic [LED_COLS-1:0][LED_ROWS-1:0]  pend_q, pend_d;
  logic [LED_COLS-1:0][LED_ROWS-1:0]  act_q, act_d;
  logic                               pflag_q, pflag_d;

  logic [5:0]  load_idx;
  logic [2:0]  col, row;
  logic        tx_load, tx_done;
  logic [23:0] tx_pixel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GAP;
      gap_q   <= '0;
      pix_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      pflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pix_q   <= pix_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      pflag_q <= pflag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    pix_d    = pix_q;
    pend_d   = pend_q;
    act_d    = act_q;
    pflag_d  = pflag_q;
    tx_load  = 1'b0;
    load_idx = pix_q + 6'd1;
    case (state_q)
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = LOAD;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      LOAD: begin
        if (pflag_q) begin
          act_d   = pend_q;
          pflag_d = 1'b0;
        end
        pix_d    = '0;
        load_idx = '0;
        tx_load  = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (tx_done) begin
          if (pix_q == 6'd63) begin
            state_d = GAP;
          end else begin
            pix_d   = pix_q + 6'd1;
            tx_load = 1'b1;
          end
        end
      end
      default: state_d = GAP;
    endcase
    // Placed last so a snapshot arriving during LOAD wins over the clear and waits a frame.
    if (bar_valid) begin
      pend_d  = bar_data;
      pflag_d = 1'b1;
    end
  end

`ifdef WS2812_BAR_PEAK_HOLD_EN
  localparam int FW = $clog2(PEAK_DECAY_FRAMES + 1);

  logic [LED_COLS-1:0][2:0] peak_q, peak_d;
  logic [FW-1:0]            fcnt_q, fcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
      fcnt_q <= '0;
    end else begin
      peak_q <= peak_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_comb begin : peak_upd
    logic       decay;
    logic [2:0] dec, hi;
    peak_d = peak_q;
    fcnt_d = fcnt_q;
    decay  = (fcnt_q == FW'(PEAK_DECAY_FRAMES - 1));
    dec    = '0;
    hi     = '0;
    if (state_q == LOAD) begin
      fcnt_d = decay ? '0 : fcnt_q + FW'(1);
      for (int c = 0; c < LED_COLS; c++) begin
        dec = (decay && peak_q[c] != 3'd0) ? peak_q[c] - 3'd1 : peak_q[c];
        hi  = hi_row(act_d[c]);
        peak_d[c] = (hi > dec) ? hi : dec;
      end
    end
  end
`else
  logic [31:0] unused_peak_cfg;
  assign unused_peak_cfg = 32'(PEAK_DECAY_FRAMES);
`endif

  // Colour uses act_d so pixel 0 loaded during LOAD already sees the fresh snapshot.
  always_comb begin
    col      = load_idx[5:3];
    row      = ((SERPENTINE != 0) && col[0]) ? ~load_idx[2:0] : load_idx[2:0];
    tx_pixel = COL_OFF;
    if (act_d[col][row]) begin
      tx_pixel = row_colour(row);
    end
`ifdef WS2812_BAR_PEAK_HOLD_EN
    else if (peak_d[col] != 3'd0 && peak_d[col] == row) begin
      tx_pixel = COL_PEAK;
    end
`endif
  end

  ws2812_bit_tx #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_tx (
    .clk        (clk),
    .rst        (rst),
    .pixel      (tx_pixel),
    .load       (tx_load),
    .dout       (ws2812_dout),
    .pixel_done (tx_done)
  );

  assign frame_busy = (state_q == SEND);
  assign frame_done = (state_q == GAP) && (gap_q == GAP_LAST);

endmodule

// File: tb/tb_ws2812_bar_drv.sv
// tb/tb_ws2812_bar_drv.sv - directed self-checking bench for ws2812_bar_drv (serpentine and straight wiring)
module tb_ws2812_bar_drv;

  localparam int T0H  = 2;
  localparam int T1H  = 4;
  localparam int TBIT = 6;
  localparam int TRST = 20;

  logic             clk;
  logic             rst;
  logic [7:0][7:0]  bar_data;
  logic             bar_valid;
  logic             dout1, busy1, done1;
  logic             dout0, busy0, done0;

  logic [23:0] px1 [64];
  logic [23:0] px0 [64];

  int checks;
  int errors;

  ws2812_bar_drv #(
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST), .SERPENTINE(1), .PEAK_DECAY_FRAMES(4)
  ) dut (
    .clk(clk), .rst(rst), .bar_data(bar_data), .bar_valid(bar_valid),
    .ws2812_dout(dout1), .frame_busy(busy1), .frame_done(done1)
  );

  ws2812_bar_drv #(
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST), .SERPENTINE(0), .PEAK_DECAY_FRAMES(4)
  ) dut_ns (
    .clk(clk), .rst(rst), .bar_data(bar_data), .bar_valid(bar_valid),
    .ws2812_dout(dout0), .frame_busy(busy0), .frame_done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int count_lit(input bit serp);
    int n;
    n = 0;
    for (int p = 0; p < 64; p++) begin
      if (serp ? (px1[p] != 24'h0) : (px0[p] != 24'h0)) n++;
    end
    return n;
  endfunction

  task automatic capture_frame(input string tag);
    int n, hi1, hi0, bad, g;
    n = 0;
    while (!busy1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_start"}, 32'(busy1), 32'd1);
    bad = 0;
    for (int p = 0; p < 64; p++) begin
      for (int b = 0; b < 24; b++) begin
        hi1 = 0;
        hi0 = 0;
        for (int c = 0; c < TBIT; c++) begin
          hi1 += int'(dout1);
          hi0 += int'(dout0);
          @(negedge clk);
        end
        if (hi1 != T0H && hi1 != T1H) bad++;
        if (hi0 != T0H && hi0 != T1H) bad++;
        px1[p] = {px1[p][22:0], (hi1 == T1H)};
        px0[p] = {px0[p][22:0], (hi0 == T1H)};
      end
    end
    check_eq({tag, "_bitshape"}, 32'(bad), 32'd0);
    check_eq({tag, "_busy_end"}, 32'(busy1), 32'd0);
    g = 0;
    bad = 0;
    while (!done1 && g < TRST + 10) begin
      if (dout1 || dout0) bad++;
      @(negedge clk);
      g++;
    end
    check_eq({tag, "_gap_len"}, 32'(g), 32'(TRST - 1));
    check_eq({tag, "_gap_low"}, 32'(bad), 32'd0);
  endtask

  task automatic wait_first_frame(input string tag);
    int k, hi;
    k = 0;
    hi = 0;
    while (!busy1 && k < 200) begin
      @(negedge clk);
      k++;
      if ((dout1 || dout0) && !busy1) hi++;
    end
    check_eq({tag, "_gap_cycles"}, 32'(k), 32'(TRST + 1));
    check_eq({tag, "_gap_dout"}, 32'(hi), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bar_valid = 1'b0;
    bar_data  = '0;
    for (int p = 0; p < 64; p++) begin
      px1[p] = '0;
      px0[p] = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_dout", 32'(dout1), 32'd0);
    check_eq("rst_dout_ns", 32'(dout0), 32'd0);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_done", 32'(done1), 32'd0);
    rst = 1'b0;

    // Frame 1: all bars zero after reset.
    wait_first_frame("boot");
    capture_frame("f1");
    check_eq("f1_lit", 32'(count_lit(1'b1)), 32'd0);
    check_eq("f1_lit_ns", 32'(count_lit(1'b0)), 32'd0);

    // Snapshot during the last gap cycle: column 0 row 0, column 1 row 7.
    bar_data    = '0;
    bar_data[0] = 8'h01;
    bar_data[1] = 8'h80;
    bar_valid   = 1'b1;
    @(negedge clk);
    bar_valid = 1'b0;
    capture_frame("f2");
    check_eq("f2_px0", 32'(px1[0]), 32'h200000);
    check_eq("f2_px8_serp", 32'(px1[8]), 32'h002000);
    check_eq("f2_lit", 32'(count_lit(1'b1)), 32'd2);
    check_eq("f2_px0_ns", 32'(px0[0]), 32'h200000);
    check_eq("f2_px15_ns", 32'(px0[15]), 32'h002000);
    check_eq("f2_lit_ns", 32'(count_lit(1'b0)), 32'd2);

    // Snapshot in the LOAD cycle, then a newer one mid-frame; frame 3 still shows the old data.
    @(negedge clk);
    bar_data    = '0;
    bar_data[3] = 8'hFF;
    bar_valid   = 1'b1;
    @(negedge clk);
    bar_valid = 1'b0;
    fork
      capture_frame("f3");
      begin
        repeat (200) @(negedge clk);
        bar_data[3] = 8'h0F;
        bar_valid   = 1'b1;
        @(negedge clk);
        bar_valid = 1'b0;
      end
    join
    check_eq("f3_px8_kept", 32'(px1[8]), 32'h002000);
    check_eq("f3_lit", 32'(count_lit(1'b1)), 32'd2);

    capture_frame("f4");
    check_eq("f4_px31", 32'(px1[31]), 32'h200000);
    check_eq("f4_px30", 32'(px1[30]), 32'h200000);
    check_eq("f4_px29", 32'(px1[29]), 32'h200000);
    check_eq("f4_px28", 32'(px1[28]), 32'h202000);
    check_eq("f4_px0_gone", 32'(px1[0]), 32'h000000);
    check_eq("f4_lit", 32'(count_lit(1'b1)), 32'd4);
    check_eq("f4_px24_ns", 32'(px0[24]), 32'h200000);
    check_eq("f4_px27_ns", 32'(px0[27]), 32'h202000);
    check_eq("f4_lit_ns", 32'(count_lit(1'b0)), 32'd4);

    // Reset while the first bit of frame 5 is high.
    begin
      int n;
      n = 0;
      while (!busy1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("mid_dout_pre", 32'(dout1), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_dout", 32'(dout1), 32'd0);
    check_eq("mid_rst_dout_ns", 32'(dout0), 32'd0);
    check_eq("mid_rst_busy", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_first_frame("mid");
    capture_frame("f6");
    check_eq("f6_lit_cleared", 32'(count_lit(1'b1)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
